// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and its hazard/sequencing controller.
// The datapath side uses master; the controller uses slave.
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             IDRs1In;
  logic [4:0]             IDRs2In;
  logic [4:0]             IDRdIn;
  logic                   IDUsesRs1In;
  logic                   IDUsesRs2In;
  logic                   IDWritesRdIn;
  logic                   RedirectIn;
  logic                   HaltIn;
  logic                   StepIn;
  logic                   PipeEnOut;
  logic                   PCWriteOut;
  logic                   IFIDWriteOut;
  logic                   IFIDFlushOut;
  logic                   IDEXFlushOut;
  logic                   EXMEMFlushOut;
  logic                   StallOut;
  logic                   HaltedOut;
  logic [STALL_CNT_W-1:0] StallCntOut;

  modport master (
    output IDRs1In, IDRs2In, IDRdIn, IDUsesRs1In, IDUsesRs2In, IDWritesRdIn,
           RedirectIn, HaltIn, StepIn,
    input  PipeEnOut, PCWriteOut, IFIDWriteOut, IFIDFlushOut, IDEXFlushOut,
           EXMEMFlushOut, StallOut, HaltedOut, StallCntOut
  );

  modport slave (
    input  IDRs1In, IDRs2In, IDRdIn, IDUsesRs1In, IDUsesRs2In, IDWritesRdIn,
           RedirectIn, HaltIn, StepIn,
    output PipeEnOut, PCWriteOut, IFIDWriteOut, IFIDFlushOut, IDEXFlushOut,
           EXMEMFlushOut, StallOut, HaltedOut, StallCntOut
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline without forwarding:
// RAW stall via a 3-slot destination scoreboard, redirect flush, run/halt/step FSM.
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clkIn,
  input  logic                   resetIn,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int SLOTS = 3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic                   run;
  logic                   halted;

  // Slot 0 = ID/EX, slot 1 = EX/MEM, slot 2 = MEM/WB.
  logic [SLOTS-1:0]       slot_v_reg;
  logic [SLOTS-1:0]       slot_v_next;
  logic [4:0]             slot_rd_reg  [SLOTS];
  logic [4:0]             slot_rd_next [SLOTS];

  logic [SLOTS-1:0]       hit_rs1;
  logic [SLOTS-1:0]       hit_rs2;
  logic                   rs1_hzd;
  logic                   rs2_hzd;
  logic                   hzd;
  logic                   new_v;

  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   exmem_flush;
  logic                   stall;

  logic [STALL_CNT_W-1:0] stall_cnt_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_next;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_match
      assign hit_rs1[gi] = slot_v_reg[gi] & (slot_rd_reg[gi] == hz.IDRs1In);
      assign hit_rs2[gi] = slot_v_reg[gi] & (slot_rd_reg[gi] == hz.IDRs2In);
    end
  endgenerate

  // The WB slot also hazards: the register file writes at the edge ending WB.
  assign rs1_hzd = hz.IDUsesRs1In & (hz.IDRs1In != 5'd0) & (|hit_rs1);
  assign rs2_hzd = hz.IDUsesRs2In & (hz.IDRs2In != 5'd0) & (|hit_rs2);
  assign hzd     = rs1_hzd | rs2_hzd;
  assign new_v   = hz.IDWritesRdIn & (hz.IDRdIn != 5'd0);

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (hz.HaltIn) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (hz.StepIn) begin
          state_next = ST_STEP;
        end else if (!hz.HaltIn) begin
          state_next = ST_RUN;
        end
      end
      ST_STEP: begin
        state_next = hz.HaltIn ? ST_HALT : ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_comb begin
    run    = 1'b0;
    halted = 1'b0;
    case (state_reg)
      ST_RUN:  run    = 1'b1;
      ST_STEP: run    = 1'b1;
      ST_HALT: halted = 1'b1;
      default: begin
        run    = 1'b0;
        halted = 1'b0;
      end
    endcase
  end

  // Redirect wins over stall: the stalled ID instruction is on the wrong path anyway.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall       = 1'b0;
    if (run) begin
      if (hz.RedirectIn) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (hzd) begin
        idex_flush  = 1'b1;
        stall       = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end
    end
  end

  // The redirecting instruction keeps flowing into WB so its own rd write stays tracked.
  always_comb begin
    slot_v_next  = slot_v_reg;
    slot_rd_next = slot_rd_reg;
    if (run) begin
      slot_v_next[2]  = slot_v_reg[1];
      slot_rd_next[2] = slot_rd_reg[1];
      if (hz.RedirectIn) begin
        slot_v_next[1]  = 1'b0;
        slot_rd_next[1] = 5'd0;
      end else begin
        slot_v_next[1]  = slot_v_reg[0];
        slot_rd_next[1] = slot_rd_reg[0];
      end
      if (hz.RedirectIn | hzd) begin
        slot_v_next[0]  = 1'b0;
        slot_rd_next[0] = 5'd0;
      end else begin
        slot_v_next[0]  = new_v;
        slot_rd_next[0] = new_v ? hz.IDRdIn : 5'd0;
      end
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && run && !(&stall_cnt_reg)) begin
      stall_cnt_next = stall_cnt_reg + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      slot_v_reg    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_rd_reg[i] <= 5'd0;
      end
      stall_cnt_reg <= '0;
    end else begin
      slot_v_reg    <= slot_v_next;
      slot_rd_reg   <= slot_rd_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign hz.PipeEnOut     = run;
  assign hz.PCWriteOut    = pc_write;
  assign hz.IFIDWriteOut  = ifid_write;
  assign hz.IFIDFlushOut  = ifid_flush;
  assign hz.IDEXFlushOut  = idex_flush;
  assign hz.EXMEMFlushOut = exmem_flush;
  assign hz.StallOut      = stall;
  assign hz.HaltedOut     = halted;
  assign hz.StallCntOut   = stall_cnt_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a reference model pushes expected
// outputs per cycle, each scenario task pops and compares what the DUT shows.
module tb_pipeline_hazard_ctrl;
  localparam int CW    = 16;
  localparam int SAT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(CW))    hz ();
  pipeline_hazard_ctrl_if #(.STALL_CNT_W(SAT_W)) hz_sat ();

  pipeline_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clkIn   (clk),
    .resetIn (rst_n),
    .hz      (hz)
  );

  // Narrow counter instance so saturation is reached in a few hundred cycles.
  pipeline_hazard_ctrl #(.STALL_CNT_W(SAT_W)) dut_sat (
    .clkIn   (clk),
    .resetIn (rst_n),
    .hz      (hz_sat)
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       w;
    logic       redir;
    logic       halt;
    logic       step;
  } stim_t;

  // ctl = {PipeEn, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Stall, Halted}
  typedef struct packed {
    logic [7:0]  ctl;
    logic [15:0] cnt;
  } res_t;

  res_t       exp_q[$];
  res_t       obs;
  int         checks = 0;
  int         errors = 0;

  logic       m_v  [3];
  logic [4:0] m_rd [3];
  int         m_state;
  int         m_cnt;

  function automatic stim_t nop_s();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t wr_s(input logic [4:0] rd);
    stim_t s;
    s = '0;
    s.rd = rd;
    s.w  = 1'b1;
    return s;
  endfunction

  function automatic stim_t rd_s(input logic [4:0] r1, input logic [4:0] r2,
                                 input logic u1, input logic u2);
    stim_t s;
    s = '0;
    s.rs1 = r1;
    s.rs2 = r2;
    s.u1  = u1;
    s.u2  = u2;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k]  = 1'b0;
      m_rd[k] = 5'd0;
    end
    m_state = 0;
    m_cnt   = 0;
  endtask

  task automatic drive_in(input stim_t s);
    hz.IDRs1In      = s.rs1;
    hz.IDRs2In      = s.rs2;
    hz.IDRdIn       = s.rd;
    hz.IDUsesRs1In  = s.u1;
    hz.IDUsesRs2In  = s.u2;
    hz.IDWritesRdIn = s.w;
    hz.RedirectIn   = s.redir;
    hz.HaltIn       = s.halt;
    hz.StepIn       = s.step;
  endtask

  // Drives one cycle (entered just after a posedge), queues the model's expectation,
  // samples the DUT at the negedge and advances the model at the next posedge.
  task automatic run_cycle(input stim_t s);
    logic run_m, hzd_m, h1, h2;
    res_t e;
    drive_in(s);
    run_m = (m_state != 1);
    h1 = 1'b0;
    h2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_v[k] && m_rd[k] == s.rs1) h1 = 1'b1;
      if (m_v[k] && m_rd[k] == s.rs2) h2 = 1'b1;
    end
    hzd_m = (s.u1 && s.rs1 != 5'd0 && h1) || (s.u2 && s.rs2 != 5'd0 && h2);
    if (!run_m)        e.ctl = 8'b0000_0001;
    else if (s.redir)  e.ctl = 8'b1111_1100;
    else if (hzd_m)    e.ctl = 8'b1000_1010;
    else               e.ctl = 8'b1110_0000;
    e.cnt = m_cnt[15:0];
    exp_q.push_back(e);
    @(negedge clk);
    obs.ctl = {hz.PipeEnOut, hz.PCWriteOut, hz.IFIDWriteOut, hz.IFIDFlushOut,
               hz.IDEXFlushOut, hz.EXMEMFlushOut, hz.StallOut, hz.HaltedOut};
    obs.cnt = hz.StallCntOut;
    @(posedge clk);
    if (run_m) begin
      m_v[2]  = m_v[1];
      m_rd[2] = m_rd[1];
      if (s.redir) begin
        m_v[1]  = 1'b0;
        m_rd[1] = 5'd0;
      end else begin
        m_v[1]  = m_v[0];
        m_rd[1] = m_rd[0];
      end
      if (s.redir || hzd_m) begin
        m_v[0]  = 1'b0;
        m_rd[0] = 5'd0;
      end else begin
        m_v[0]  = s.w && (s.rd != 5'd0);
        m_rd[0] = s.rd;
      end
      if (!s.redir && hzd_m && m_cnt < 65535) m_cnt++;
    end
    case (m_state)
      0: if (s.halt) m_state = 1;
      1: if (s.step) m_state = 2; else if (!s.halt) m_state = 0;
      default: m_state = s.halt ? 1 : 0;
    endcase
    #1;
  endtask

  task automatic test_reset();
    drive_in(rd_s(5'd5, 5'd0, 1'b1, 1'b0));
    hz_sat.IDRs1In = 5'd0; hz_sat.IDRs2In = 5'd0; hz_sat.IDRdIn = 5'd0;
    hz_sat.IDUsesRs1In = 1'b0; hz_sat.IDUsesRs2In = 1'b0; hz_sat.IDWritesRdIn = 1'b0;
    hz_sat.RedirectIn = 1'b0; hz_sat.HaltIn = 1'b0; hz_sat.StepIn = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    obs.ctl = {hz.PipeEnOut, hz.PCWriteOut, hz.IFIDWriteOut, hz.IFIDFlushOut,
               hz.IDEXFlushOut, hz.EXMEMFlushOut, hz.StallOut, hz.HaltedOut};
    obs.cnt = hz.StallCntOut;
    checks++;
    if (obs.ctl !== 8'b1110_0000 || obs.cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: ctl=%b cnt=%0d, want ctl=11100000 cnt=0", obs.ctl, obs.cnt);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset: ctl=%b cnt=%0d", obs.ctl, obs.cnt);
  endtask

  // Writer of x5, then gap independent writers, then a reader of x5.
  task automatic test_raw_gap();
    stim_t s;
    res_t  e;
    int    stalls;
    for (int gap = 0; gap < 4; gap++) begin
      stalls = 0;
      for (int c = 0; c < 10 + gap; c++) begin
        if (c < 4)             s = nop_s();
        else if (c == 4)       s = wr_s(5'd5);
        else if (c < 5 + gap)  s = wr_s(5'd9);
        else                   s = rd_s(5'd5, 5'd1, 1'b1, 1'b1);
        run_cycle(s);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL raw_gap%0d cyc%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   gap, c, obs.ctl, obs.cnt, e.ctl, e.cnt);
        end
        if (obs.ctl[1]) begin
          stalls++;
          checks++;
          if (obs.ctl[3] !== 1'b1 || obs.ctl[6] !== 1'b0) begin
            errors++;
            $display("FAIL raw_gap%0d stall_ctl cyc%0d: idex_flush=%b pc_write=%b, want 1 0",
                     gap, c, obs.ctl[3], obs.ctl[6]);
          end
        end
      end
      checks++;
      if (stalls != 3 - gap) begin
        errors++;
        $display("FAIL raw_gap%0d stall_len: got %0d cycles, want %0d", gap, stalls, 3 - gap);
      end
      if (gap == 0) begin
        checks++;
        if (obs.cnt !== 16'd3) begin
          errors++;
          $display("FAIL raw_gap0 stall_cnt: got %0d, want 3", obs.cnt);
        end
      end
      $display("raw_gap%0d: stall cycles=%0d cnt=%0d", gap, stalls, obs.cnt);
    end
  endtask

  task automatic test_x0_and_unused();
    stim_t s;
    res_t  e;
    for (int c = 0; c < 7; c++) begin
      case (c)
        3:       s = wr_s(5'd0);
        4:       s = rd_s(5'd0, 5'd0, 1'b1, 1'b1);
        5:       s = wr_s(5'd7);
        6:       s = rd_s(5'd3, 5'd7, 1'b0, 1'b0);
        default: s = nop_s();
      endcase
      run_cycle(s);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL x0_unused cyc%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 c, obs.ctl, obs.cnt, e.ctl, e.cnt);
      end
      if (c == 4 || c == 6) begin
        checks++;
        if (obs.ctl[1] !== 1'b0) begin
          errors++;
          $display("FAIL x0_unused no_stall cyc%0d: stall=%b, want 0", c, obs.ctl[1]);
        end
      end
    end
    $display("x0_unused: done");
  endtask

  // JAL x1 reaches EX/MEM while a reader of x5 stalls behind a writer of x5.
  task automatic test_redirect();
    stim_t s;
    res_t  e;
    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c < 7; c++) begin
        case (c)
          3: s = wr_s(5'd1);
          4: s = wr_s(5'd5);
          5: begin
            s = rd_s(5'd5, 5'd0, 1'b1, 1'b0);
            s.redir = 1'b1;
          end
          6: s = (v == 0) ? rd_s(5'd1, 5'd0, 1'b1, 1'b0) : rd_s(5'd5, 5'd0, 1'b1, 1'b0);
          default: s = nop_s();
        endcase
        run_cycle(s);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL redirect v%0d cyc%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   v, c, obs.ctl, obs.cnt, e.ctl, e.cnt);
        end
        if (c == 5) begin
          checks++;
          if (obs.ctl !== 8'b1111_1100) begin
            errors++;
            $display("FAIL redirect_ctl v%0d: ctl=%b, want 11111100", v, obs.ctl);
          end
        end
        if (c == 6) begin
          checks++;
          if (obs.ctl[1] !== (v == 0)) begin
            errors++;
            $display("FAIL redirect_after v%0d: stall=%b, want %0d", v, obs.ctl[1], (v == 0));
          end
        end
      end
      $display("redirect v%0d: after-edge stall=%b", v, obs.ctl[1]);
    end
  endtask

  task automatic test_halt_step();
    stim_t s;
    res_t  e;
    logic  pe_want [8];
    logic  hl_want [8];
    pe_want = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    hl_want = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 8; c++) begin
      s = nop_s();
      s.halt = (c < 5);
      s.step = (c == 2) || (c == 6);
      run_cycle(s);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL halt_step cyc%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 c, obs.ctl, obs.cnt, e.ctl, e.cnt);
      end
      checks++;
      if (obs.ctl[7] !== pe_want[c] || obs.ctl[0] !== hl_want[c]) begin
        errors++;
        $display("FAIL halt_step_seq cyc%0d: pipe_en=%b halted=%b, want %b %b",
                 c, obs.ctl[7], obs.ctl[0], pe_want[c], hl_want[c]);
      end
      $display("halt_step cyc%0d: pipe_en=%b halted=%b", c, obs.ctl[7], obs.ctl[0]);
    end
  endtask

  task automatic test_reset_in_halt();
    stim_t s;
    res_t  e;
    for (int c = 0; c < 7; c++) begin
      if (c == 3)      s = wr_s(5'd5);
      else if (c > 3) begin
        s = rd_s(5'd5, 5'd0, 1'b1, 1'b0);
        s.halt = (c >= 4);
      end else         s = nop_s();
      run_cycle(s);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_halt cyc%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 c, obs.ctl, obs.cnt, e.ctl, e.cnt);
      end
    end
    checks++;
    if (obs.ctl !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_halt pre: ctl=%b, want 00000001", obs.ctl);
    end
    rst_n = 1'b0;
    #1;
    obs.ctl = {hz.PipeEnOut, hz.PCWriteOut, hz.IFIDWriteOut, hz.IFIDFlushOut,
               hz.IDEXFlushOut, hz.EXMEMFlushOut, hz.StallOut, hz.HaltedOut};
    obs.cnt = hz.StallCntOut;
    checks++;
    if (obs.ctl !== 8'b1110_0000 || obs.cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_halt async: ctl=%b cnt=%0d, want ctl=11100000 cnt=0", obs.ctl, obs.cnt);
    end
    model_reset();
    s = rd_s(5'd5, 5'd0, 1'b1, 1'b0);
    drive_in(s);
    #1 rst_n = 1'b1;
    run_cycle(s);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || obs.ctl[0] !== 1'b0 || obs.ctl[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_halt post: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
               obs.ctl, obs.cnt, e.ctl, e.cnt);
    end
    $display("reset_halt: post-release ctl=%b", obs.ctl);
  endtask

  task automatic test_back_to_back();
    stim_t s;
    res_t  e;
    logic  halt_lvl;
    int    errs_before;
    halt_lvl    = 1'b0;
    errs_before = errors;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 9) == 0) halt_lvl = ~halt_lvl;
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.rd    = 5'($urandom_range(0, 7));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.w     = 1'($urandom_range(0, 1));
      s.redir = ($urandom_range(0, 7) == 0);
      s.halt  = halt_lvl;
      s.step  = ($urandom_range(0, 3) == 0);
      run_cycle(s);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 c, obs.ctl, obs.cnt, e.ctl, e.cnt);
      end
    end
    $display("back_to_back: 300 cycles, %0d new errors", errors - errs_before);
  endtask

  // add x5,x5,x1 held in ID: 3 stall cycles out of every 4.
  task automatic test_stall_saturate();
    logic [SAT_W-1:0] q[$];
    logic [SAT_W-1:0] want;
    int               seen;
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      hz_sat.IDRs1In      = 5'd5;
      hz_sat.IDRs2In      = 5'd1;
      hz_sat.IDRdIn       = 5'd5;
      hz_sat.IDUsesRs1In  = 1'b1;
      hz_sat.IDUsesRs2In  = 1'b1;
      hz_sat.IDWritesRdIn = 1'b1;
      q.push_back((seen > 255) ? 8'hFF : SAT_W'(seen));
      @(negedge clk);
      want = q.pop_front();
      checks++;
      if (hz_sat.StallCntOut !== want) begin
        errors++;
        $display("FAIL saturate cyc%0d: cnt=%0d, want %0d", c, hz_sat.StallCntOut, want);
      end
      if (hz_sat.StallOut === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 300 || hz_sat.StallCntOut !== 8'hFF) begin
      errors++;
      $display("FAIL saturate_final: stalls=%0d cnt=%0d, want 300 and 255", seen, hz_sat.StallCntOut);
    end
    hz_sat.IDUsesRs1In  = 1'b0;
    hz_sat.IDUsesRs2In  = 1'b0;
    hz_sat.IDWritesRdIn = 1'b0;
    $display("saturate: stalls=%0d cnt=%0d", seen, hz_sat.StallCntOut);
  endtask

  initial begin
    test_reset();
    test_raw_gap();
    test_x0_and_unused();
    test_redirect();
    test_halt_step();
    test_back_to_back();
    test_reset_in_halt();
    test_stall_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
